// File: rtl/jtcop_obj_pkg.sv
// jtcop_obj_pkg: entry field offsets, table word indices and FSM states for the object scheduler
package jtcop_obj_pkg;
    localparam int TILE_W = 16;
    localparam int W0_EN = 15;
    localparam int W0_VFLIP = 14;
    localparam int W0_HFLIP = 13;
    localparam int W0_NSIZE = 11;
    localparam int W0_MSIZE = 9;
    localparam int W2_PAL = 12;
    localparam int W2_BLINK = 11;
    localparam logic [1:0] WD_ATTR = 2'd0;
    localparam logic [1:0] WD_CODE = 2'd1;
    localparam logic [1:0] WD_POS = 2'd2;
    typedef enum logic [2:0] {ST_IDLE, ST_RD0, ST_RD1, ST_RD2, ST_EMIT, ST_DONE} state_t;
    function automatic logic [2:0] size_mask(input logic [1:0] n);
        return 3'((4'd1 << n) - 4'd1);
    endfunction
endpackage

// File: rtl/jtcop_obj_zone.sv
// jtcop_obj_zone: vertical hit test and tile row/sub-row math for one object attribute word
module jtcop_obj_zone
    import jtcop_obj_pkg::*;
(
    input  logic [15:0] w0,
    input  logic [8:0]  vrender,
    output logic        hit,
    output logic [2:0]  row,
    output logic [3:0]  vsub,
    output logic [1:0]  msize,
    output logic [1:0]  nsize,
    output logic        hflip
);
    logic [8:0] dy;
    logic [2:0] rmask, rraw;
    logic vflip;
    assign msize = w0[W0_MSIZE +: 2];
    assign nsize = w0[W0_NSIZE +: 2];
    assign hflip = w0[W0_HFLIP];
    assign vflip = w0[W0_VFLIP];
    assign dy = vrender - w0[8:0];
    assign rmask = size_mask(msize);
    assign rraw = dy[6:4] & rmask;
    assign hit = w0[W0_EN] && dy < (9'(TILE_W) << msize);
    assign row = vflip ? rmask - rraw : rraw;
    assign vsub = vflip ? ~dy[3:0] : dy[3:0];
endmodule

// File: rtl/jtcop_obj_sched.sv
// jtcop_obj_sched: per-line object table scan expanding hits into 16-px tile requests
// Define JTCOP_OBJ_BLINK_EN to honour the blink bit (frame toggles on lvbl falling edge).
module jtcop_obj_sched
    import jtcop_obj_pkg::*;
#(
    parameter int NOBJ  = 256,
    parameter int MAXTL = 32
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hs,
    input  logic        lvbl,
    input  logic [8:0]  vrender,
    output logic [9:0]  tbl_addr,
    input  logic [15:0] tbl_dout,
    output logic        dr_valid,
    input  logic        dr_ready,
    output logic [15:0] dr_code,
    output logic [8:0]  dr_xpos,
    output logic [3:0]  dr_vsub,
    output logic [3:0]  dr_pal,
    output logic        dr_hflip,
    output logic        dr_first,
    output logic        busy,
    output logic        ovf_tl,
    output logic        ovf_line
);
    localparam int CW = $clog2(MAXTL + 1);
    state_t st, st_nx;
    logic ph, ph_nx, hs_l, hs_fall, xfer, nxt_ent, load, ovf_t, more, blk, last;
    logic z_hit, z_hf, hf_l;
    logic [7:0] ent;
    logic [CW-1:0] cnt, cnt_inc;
    logic [2:0] kcol, kn, c, z_row, row_l;
    logic [3:0] z_vsub, vsub_l, pal_l, pb;
    logic [1:0] z_msz, z_nsz, msz_l, nsz_l;
    logic [15:0] code_l;
    logic [8:0] xpos_l, vr, xb;

    jtcop_obj_zone u_zone (
        .w0      (tbl_dout),
        .vrender (vr),
        .hit     (z_hit),
        .row     (z_row),
        .vsub    (z_vsub),
        .msize   (z_msz),
        .nsize   (z_nsz),
        .hflip   (z_hf)
    );

`ifdef JTCOP_OBJ_BLINK_EN
    logic lvbl_l, frame;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvbl_l <= 1'b0;
            frame  <= 1'b0;
        end else begin
            lvbl_l <= lvbl;
            if (lvbl_l && !lvbl) frame <= ~frame;
        end
    end
    assign blk = tbl_dout[W2_BLINK] & frame;
`else
    assign blk = 1'b0 & lvbl;
`endif

    assign busy = st != ST_IDLE && st != ST_DONE;
    assign hs_fall = hs_l & ~hs;
    assign xfer = dr_valid & dr_ready;
    assign cnt_inc = cnt + CW'(xfer);
    assign last = ent == 8'(NOBJ - 1);
    assign more = kcol != size_mask(nsz_l);
    // first column reads position/palette straight off the table, later ones from the latches
    assign xb = st == ST_RD2 ? tbl_dout[8:0] : xpos_l;
    assign pb = st == ST_RD2 ? tbl_dout[W2_PAL +: 4] : pal_l;
    assign c = hf_l ? size_mask(nsz_l) - kn : kn;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st <= ST_IDLE;
            ph <= 1'b0;
        end else begin
            st <= st_nx;
            ph <= ph_nx;
        end
    end

    always_comb begin
        st_nx = st;
        nxt_ent = 1'b0;
        load = 1'b0;
        kn = 3'd0;
        ovf_t = 1'b0;
        case (st)
            ST_RD0: if (ph) begin
                if (z_hit) st_nx = ST_RD1;
                else nxt_ent = 1'b1;
            end
            ST_RD1: if (ph) st_nx = ST_RD2;
            ST_RD2: if (ph) begin
                if (blk) nxt_ent = 1'b1;
                else if (cnt == CW'(MAXTL)) begin
                    ovf_t = 1'b1;
                    st_nx = ST_DONE;
                end else begin
                    load = 1'b1;
                    st_nx = ST_EMIT;
                end
            end
            ST_EMIT: if (xfer) begin
                if (!more) nxt_ent = 1'b1;
                else if (cnt_inc == CW'(MAXTL)) begin
                    ovf_t = 1'b1;
                    st_nx = ST_DONE;
                end else begin
                    load = 1'b1;
                    kn = kcol + 3'd1;
                end
            end
            ST_DONE: st_nx = ST_IDLE;
            default: ;
        endcase
        if (nxt_ent) st_nx = last ? ST_DONE : ST_RD0;
        ph_nx = (st_nx == st && st inside {ST_RD0, ST_RD1, ST_RD2}) ? ~ph : 1'b0;
        if (hs_fall) begin
            st_nx = ST_RD0;
            ph_nx = 1'b0;
            nxt_ent = 1'b0;
            load = 1'b0;
            ovf_t = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_l <= 1'b0;
            ovf_tl <= 1'b0;
            ovf_line <= 1'b0;
            ent <= 8'd0;
            tbl_addr <= 10'd0;
            cnt <= '0;
            vr <= 9'd0;
            row_l <= 3'd0;
            vsub_l <= 4'd0;
            msz_l <= 2'd0;
            nsz_l <= 2'd0;
            hf_l <= 1'b0;
            code_l <= 16'd0;
            xpos_l <= 9'd0;
            pal_l <= 4'd0;
            kcol <= 3'd0;
            dr_valid <= 1'b0;
            dr_code <= 16'd0;
            dr_xpos <= 9'd0;
            dr_vsub <= 4'd0;
            dr_pal <= 4'd0;
            dr_hflip <= 1'b0;
            dr_first <= 1'b0;
        end else begin
            hs_l <= hs;
            ovf_tl <= ovf_t;
            ovf_line <= hs_fall & busy;
            if (hs_fall) begin
                ent <= 8'd0;
                tbl_addr <= 10'd0;
                cnt <= '0;
                vr <= vrender;
                dr_valid <= 1'b0;
                dr_first <= 1'b0;
            end else begin
                cnt <= cnt_inc;
                if (st == ST_RD0 && ph && z_hit) begin
                    row_l <= z_row;
                    vsub_l <= z_vsub;
                    msz_l <= z_msz;
                    nsz_l <= z_nsz;
                    hf_l <= z_hf;
                    tbl_addr[1:0] <= WD_CODE;
                end
                if (st == ST_RD1 && ph) begin
                    code_l <= tbl_dout;
                    tbl_addr[1:0] <= WD_POS;
                end
                if (st == ST_RD2 && ph) begin
                    xpos_l <= tbl_dout[8:0];
                    pal_l <= tbl_dout[W2_PAL +: 4];
                end
                if (nxt_ent) begin
                    ent <= ent + 8'd1;
                    tbl_addr <= {ent + 8'd1, WD_ATTR};
                end
                if (load) begin
                    dr_valid <= 1'b1;
                    dr_code <= code_l + (16'(c) << msz_l) + 16'(row_l);
                    dr_xpos <= xb + 9'(kn * TILE_W);
                    dr_vsub <= vsub_l;
                    dr_pal <= pb;
                    dr_hflip <= hf_l;
                    dr_first <= (cnt_inc == '0);
                    kcol <= kn;
                end else if (xfer) begin
                    dr_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_jtcop_obj_sched.sv
// tb_jtcop_obj_sched: scoreboard bench with a per-line reference model of the object scheduler
module tb_jtcop_obj_sched;
    typedef struct packed {
        logic [15:0] code;
        logic [8:0]  xpos;
        logic [3:0]  vsub;
        logic [3:0]  pal;
        logic        hflip;
        logic        first;
    } tile_t;

    logic clk, rst_n, hs, lvbl, dr_valid, dr_ready, dr_hflip, dr_first, busy, ovf_tl, ovf_line;
    logic [8:0] vrender, dr_xpos;
    logic [9:0] tbl_addr;
    logic [15:0] tbl_dout, dr_code;
    logic [3:0] dr_vsub, dr_pal;
    logic [15:0] mem [1024];

    tile_t q[$];
    tile_t cur, ptile, e;
    int errs = 0, checks = 0, n_otl = 0, n_oln = 0, nx = 0, rdy_mode = 0;
    bit m_ovf, bframe, stab_en, pv, pr;

    jtcop_obj_sched dut (
        .clk(clk), .rst_n(rst_n), .hs(hs), .lvbl(lvbl), .vrender(vrender),
        .tbl_addr(tbl_addr), .tbl_dout(tbl_dout), .dr_valid(dr_valid), .dr_ready(dr_ready),
        .dr_code(dr_code), .dr_xpos(dr_xpos), .dr_vsub(dr_vsub), .dr_pal(dr_pal),
        .dr_hflip(dr_hflip), .dr_first(dr_first), .busy(busy), .ovf_tl(ovf_tl), .ovf_line(ovf_line)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) tbl_dout <= mem[tbl_addr];

    initial begin
        dr_ready = 0;
        forever begin
            @(posedge clk);
            #1 dr_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ($urandom_range(0, 9) < 7) : 1'b0;
        end
    end

    assign cur = '{dr_code, dr_xpos, dr_vsub, dr_pal, dr_hflip, dr_first};

    always @(negedge clk) begin
        if (!rst_n) pv = 0;
        else begin
            if (ovf_tl) n_otl++;
            if (ovf_line) n_oln++;
            if (stab_en && pv && !pr) begin
                checks++;
                if (!dr_valid || cur !== ptile) begin
                    errs++;
                    $display("FAIL stall_hold: got v=%0b %h want v=1 %h", dr_valid, cur, ptile);
                end
            end
            if (dr_valid && dr_ready) begin
                checks++;
                nx++;
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_xfer: got %h want none", cur);
                end else begin
                    e = q.pop_front();
                    if (cur !== e) begin
                        errs++;
                        $display("FAIL xfer: got code=%h x=%0d vs=%0d pal=%h hf=%0b f=%0b want code=%h x=%0d vs=%0d pal=%h hf=%0b f=%0b",
                                 cur.code, cur.xpos, cur.vsub, cur.pal, cur.hflip, cur.first,
                                 e.code, e.xpos, e.vsub, e.pal, e.hflip, e.first);
                    end
                end
            end
            pv = dr_valid;
            pr = dr_ready;
            ptile = cur;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: walk the table in order, draw every enabled entry whose band covers the line.
    task automatic model_line(input logic [8:0] vr);
        int n = 0;
        bit stop = 0;
        m_ovf = 0;
        for (int i = 0; i < 256 && !stop; i++) begin
            logic [15:0] w0 = mem[i*4], w1 = mem[i*4+1], w2 = mem[i*4+2];
            int dy = (int'(vr) - int'(w0[8:0]) + 512) % 512;
            int rows = 1 << int'(w0[10:9]);
            int cols = 1 << int'(w0[12:11]);
            int r, vs;
            bit skip = !w0[15] || dy >= 16 * rows;
`ifdef JTCOP_OBJ_BLINK_EN
            if (w2[11] && bframe) skip = 1;
`endif
            if (!skip) begin
                r = (dy / 16) % rows;
                vs = dy % 16;
                if (w0[14]) begin
                    r = rows - 1 - r;
                    vs = 15 - vs;
                end
                for (int k = 0; k < cols && !stop; k++) begin
                    int cc = w0[13] ? cols - 1 - k : k;
                    tile_t t;
                    if (n == 32) begin
                        m_ovf = 1;
                        stop = 1;
                    end else begin
                        t.code = 16'(int'(w1) + cc * rows + r);
                        t.xpos = 9'(int'(w2[8:0]) + 16 * k);
                        t.vsub = 4'(vs);
                        t.pal = w2[15:12];
                        t.hflip = w0[13];
                        t.first = n == 0;
                        q.push_back(t);
                        n++;
                    end
                end
            end
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 1024; i++) mem[i] = 16'd0;
    endtask

    task automatic set_ent(input int i, input bit vf, input bit hf, input int ns, input int ms,
                           input int yp, input int code, input int pal, input bit bl, input int xp);
        mem[i*4] = {1'b1, vf, hf, 2'(ns), 2'(ms), 9'(yp)};
        mem[i*4+1] = 16'(code);
        mem[i*4+2] = {4'(pal), bl, 2'b0, 9'(xp)};
    endtask

    task automatic pulse_hs();
        @(posedge clk);
        #1 hs = 0;
        @(posedge clk);
        #1 hs = 1;
    endtask

    task automatic start_line(input logic [8:0] vr);
        vrender = vr;
        model_line(vr);
        pulse_hs();
    endtask

    task automatic finish_line(input string nm, input int exp_ovf, input int exp_oln);
        int i = 0;
        while (i < 5000) begin
            @(negedge clk);
            if (!busy) break;
            i++;
        end
        if (i == 5000) begin
            errs++;
            checks++;
            $display("FAIL %s_timeout: got busy=1 after %0d clks want busy=0", nm, i);
        end
        repeat (3) @(negedge clk);
        chk({nm, "_drain"}, q.size(), 0);
        chk({nm, "_ovf_tl"}, n_otl, exp_ovf);
        chk({nm, "_ovf_line"}, n_oln, exp_oln);
        q.delete();
        n_otl = 0;
        n_oln = 0;
    endtask

    task automatic wait_nx(input int target);
        for (int i = 0; i < 2000 && nx < target; i++) @(negedge clk);
        chk("wait_xfer", 32'(nx >= target), 1);
    endtask

    task automatic toggle_frame();
        @(posedge clk);
        #1 lvbl = 0;
        @(posedge clk);
        #1 lvbl = 1;
        bframe = ~bframe;
    endtask

    task automatic rand_table(input logic [8:0] vr);
        for (int i = 0; i < 256; i++) begin
            logic [15:0] w0 = 16'($urandom);
            w0[15] = $urandom_range(0, 5) == 0;
            if ($urandom_range(0, 1) == 1) w0[8:0] = vr - 9'($urandom_range(0, 130));
            mem[i*4] = w0;
            mem[i*4+1] = 16'($urandom);
            mem[i*4+2] = 16'($urandom);
            mem[i*4+3] = 16'($urandom);
        end
    endtask

    initial begin
        logic [8:0] vr;
        rst_n = 0; hs = 1; lvbl = 1; vrender = 0; bframe = 0; stab_en = 1;
        clr();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", 32'(tbl_addr), 0);
        chk("rst_dr", {dr_valid, dr_code, dr_xpos, dr_vsub, dr_pal, dr_hflip, dr_first}, 0);
        chk("rst_flags", {busy, ovf_tl, ovf_line}, 0);
        @(posedge clk);
        #1 rst_n = 1;

        set_ent(0, 0, 0, 0, 0, 100, 16'h40, 3, 0, 50);
        start_line(105);
        @(negedge clk);
        chk("busy_on", 32'(busy), 1);
        finish_line("single", 0, 0);

        clr();
        set_ent(0, 0, 0, 2, 1, 60, 16'h100, 5, 0, 200);
        start_line(80);
        wait_nx(nx + 2);
        rdy_mode = 2;
        repeat (10) @(negedge clk);
        rdy_mode = 0;
        finish_line("cols_stall", 0, 0);

        set_ent(0, 1, 1, 2, 1, 60, 16'h100, 5, 0, 200);
        start_line(80);
        finish_line("flip", 0, 0);

        clr();
        for (int i = 0; i < 40; i++) set_ent(i * 3, 0, 0, 0, 0, 30, 16'h200 + i, i, 0, i * 7);
        start_line(30);
        finish_line("maxtl", 1, 0);

        clr();
        set_ent(7, 0, 0, 0, 1, 500, 16'h300, 1, 0, 10);
        start_line(4);
        finish_line("wrap", 0, 0);

        clr();
        for (int i = 100; i < 110; i++) set_ent(i, 0, 0, 1, 0, 20, 16'h500 + i, 2, 0, i);
        vrender = 25;
        pulse_hs();
        repeat (40) @(negedge clk);
        chk("abort_busy", 32'(busy), 1);
        model_line(25);
        pulse_hs();
        @(negedge clk);
        chk("abort_ovf_line", 32'(ovf_line), 1);
        chk("abort_addr", 32'(tbl_addr), 0);
        finish_line("abort", 0, 1);

        clr();
        set_ent(3, 0, 0, 1, 0, 40, 16'h700, 9, 1, 80);
        set_ent(4, 0, 0, 0, 0, 40, 16'h800, 6, 0, 90);
        for (int f = 0; f < 3; f++) begin
            start_line(45);
            finish_line("blink", 0, 0);
            toggle_frame();
        end

        rdy_mode = 1;
        for (int l = 0; l < 12; l++) begin
            vr = 9'($urandom);
            rand_table(vr);
            start_line(vr);
            finish_line("random", int'(m_ovf), 0);
            if (l % 3 == 1) toggle_frame();
        end
        rdy_mode = 0;

        clr();
        for (int i = 0; i < 5; i++) set_ent(i, 0, 0, 3, 0, 70, 16'h900 + 16 * i, 4, 0, 0);
        start_line(72);
        wait_nx(nx + 3);
        stab_en = 0;
        rdy_mode = 2;
        @(posedge clk);
        #2 rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_addr", 32'(tbl_addr), 0);
        chk("rstmid_dr", {dr_valid, dr_code, dr_xpos, dr_vsub, dr_pal, dr_hflip, dr_first}, 0);
        chk("rstmid_flags", {busy, ovf_tl, ovf_line}, 0);
        q.delete();
        @(posedge clk);
        #1 rst_n = 1;
        bframe = 0;
        rdy_mode = 0;
        stab_en = 1;
        n_otl = 0;
        n_oln = 0;
        set_ent(0, 0, 0, 0, 0, 100, 16'h40, 3, 0, 50);
        start_line(105);
        finish_line("after_rst", 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
